// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_stall_ctrl_pkg: shared state encoding and register constants for the stall controller
package pipe_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_ERR  = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_stall_ctrl_hazard_detect.sv
// pipe_stall_ctrl_hazard_detect: load-use compare between the EX load and the ID source registers
module pipe_stall_ctrl_hazard_detect
    import pipe_stall_ctrl_pkg::*;
(
    input  logic [4:0] rs_id,
    input  logic [4:0] rt_id,
    input  logic       use_rs_id,
    input  logic       use_rt_id,
    input  logic [4:0] rw_ex,
    input  logic       wreg_ex,
    input  logic       m2reg_ex,
    output logic       lu_stall
);

    // r0 never carries a dependency, so a load targeting it is never a hazard
    always_comb begin
        lu_stall = m2reg_ex && wreg_ex && (rw_ex != REG_ZERO) &&
                   ((use_rs_id && (rs_id == rw_ex)) || (use_rt_id && (rt_id == rw_ex)));
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: pipeline enable/flush scheduler with data-memory handshake and stall counter
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5,
    parameter int PERF_W      = 16
) (
    input  logic              clock,
    input  logic              reset_0,
    input  logic [4:0]        rs_id,
    input  logic [4:0]        rt_id,
    input  logic              use_rs_id,
    input  logic              use_rt_id,
    input  logic [4:0]        rw_ex,
    input  logic              wreg_ex,
    input  logic              m2reg_ex,
    input  logic              branch_taken_ex,
    input  logic              m2reg_me,
    input  logic              wmem_me,
    output logic              dmem_req,
    input  logic              dmem_ack,
    output logic              en_pc,
    output logic              en_ifid,
    output logic              en_idex,
    output logic              en_exme,
    output logic              en_mewb,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              mem_err,
    output logic [PERF_W-1:0] stall_cnt
);

    state_t             state, state_nx;
    logic [CNT_W-1:0]   wait_cnt, cnt_nx;
    logic               done, done_nx, req_nx, err_nx, lu_stall, mem_access;

    assign mem_access = m2reg_me | wmem_me;

    pipe_stall_ctrl_hazard_detect u_hazard (
        .rs_id    (rs_id),
        .rt_id    (rt_id),
        .use_rs_id(use_rs_id),
        .use_rt_id(use_rt_id),
        .rw_ex    (rw_ex),
        .wreg_ex  (wreg_ex),
        .m2reg_ex (m2reg_ex),
        .lu_stall (lu_stall)
    );

    // Control registers and the saturating stall-cycle counter
    always_ff @(posedge clock or negedge reset_0) begin
        if (!reset_0) begin
            state     <= RUN;
            dmem_req  <= 1'b0;
            wait_cnt  <= '0;
            done      <= 1'b0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nx;
            dmem_req <= req_nx;
            wait_cnt <= cnt_nx;
            done     <= done_nx;
            mem_err  <= err_nx;
            if (!en_pc && stall_cnt != '1)
                stall_cnt <= stall_cnt + PERF_W'(1);
        end
    end

    // Next state and pipeline controls; hazards only matter once memory has released the pipe
    always_comb begin
        state_nx   = state;
        req_nx     = dmem_req;
        cnt_nx     = wait_cnt;
        done_nx    = done;
        err_nx     = mem_err;
        en_pc      = 1'b0;
        en_ifid    = 1'b0;
        en_idex    = 1'b0;
        en_exme    = 1'b0;
        en_mewb    = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        case (state)
            RUN: begin
                if (mem_access && !done) begin
                    state_nx = MEM_WAIT;
                    req_nx   = 1'b1;
                    cnt_nx   = '0;
                end else begin
                    if (mem_access)
                        done_nx = 1'b0;
                    en_idex = 1'b1;
                    en_exme = 1'b1;
                    en_mewb = 1'b1;
                    if (branch_taken_ex) begin
                        en_pc      = 1'b1;
                        en_ifid    = 1'b1;
                        flush_ifid = 1'b1;
                        flush_idex = 1'b1;
                    end else if (lu_stall) begin
                        flush_idex = 1'b1;
                    end else begin
                        en_pc   = 1'b1;
                        en_ifid = 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                cnt_nx = wait_cnt + CNT_W'(1);
                if (dmem_ack) begin
                    state_nx = RUN;
                    req_nx   = 1'b0;
                    done_nx  = 1'b1;
                end else if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                    state_nx = MEM_ERR;
                    req_nx   = 1'b0;
                    err_nx   = 1'b1;
                end
            end
            default: begin
                state_nx = MEM_ERR;
                req_nx   = 1'b0;
                err_nx   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed checks of hazard, branch, memory handshake, timeout and reset behaviour
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset_0;
    logic [4:0]  rs_id, rt_id, rw_ex;
    logic        use_rs_id, use_rt_id, wreg_ex, m2reg_ex, branch_taken_ex;
    logic        m2reg_me, wmem_me, dmem_ack;
    logic        dmem_req, en_pc, en_ifid, en_idex, en_exme, en_mewb;
    logic        flush_ifid, flush_idex, mem_err;
    logic [15:0] stall_cnt;
    logic [6:0]  ctl;
    int          errors = 0;
    int          checks = 0;

    localparam logic [6:0] ADV  = 7'b1111100;
    localparam logic [6:0] HALT = 7'b0000000;
    localparam logic [6:0] LU   = 7'b0011101;
    localparam logic [6:0] BR   = 7'b1111111;

    assign ctl = {en_pc, en_ifid, en_idex, en_exme, en_mewb, flush_ifid, flush_idex};

    always #5 clk = ~clk;

    pipe_stall_ctrl dut (
        .clock          (clk),
        .reset_0        (reset_0),
        .rs_id          (rs_id),
        .rt_id          (rt_id),
        .use_rs_id      (use_rs_id),
        .use_rt_id      (use_rt_id),
        .rw_ex          (rw_ex),
        .wreg_ex        (wreg_ex),
        .m2reg_ex       (m2reg_ex),
        .branch_taken_ex(branch_taken_ex),
        .m2reg_me       (m2reg_me),
        .wmem_me        (wmem_me),
        .dmem_req       (dmem_req),
        .dmem_ack       (dmem_ack),
        .en_pc          (en_pc),
        .en_ifid        (en_ifid),
        .en_idex        (en_idex),
        .en_exme        (en_exme),
        .en_mewb        (en_mewb),
        .flush_ifid     (flush_ifid),
        .flush_idex     (flush_idex),
        .mem_err        (mem_err),
        .stall_cnt      (stall_cnt)
    );

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        {rs_id, rt_id, rw_ex} = '0;
        {use_rs_id, use_rt_id, wreg_ex, m2reg_ex, branch_taken_ex} = '0;
        {m2reg_me, wmem_me, dmem_ack} = '0;
        reset_0 = 1'b0;
        #2;
        reset_0 = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        {rs_id, rt_id, rw_ex} = '0;
        {use_rs_id, use_rt_id, wreg_ex, m2reg_ex, branch_taken_ex} = '0;
        {m2reg_me, wmem_me, dmem_ack} = '0;
        reset_0 = 1'b0;
        cyc(2);
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", dmem_req); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", mem_err); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", stall_cnt); end
        checks++; if (ctl !== ADV) begin errors++; $display("FAIL rst_ctl got=%b exp=%b", ctl, ADV); end
        reset_0 = 1'b1;
        cyc();
    endtask

    task automatic test_load_use();
        do_reset();
        m2reg_ex = 1'b1; wreg_ex = 1'b1; rw_ex = 5'd5; rs_id = 5'd5; use_rs_id = 1'b1;
        #1;
        checks++; if (ctl !== LU) begin errors++; $display("FAIL lu_rs got=%b exp=%b", ctl, LU); end
        cyc();
        use_rs_id = 1'b0; rt_id = 5'd5; use_rt_id = 1'b1;
        #1;
        checks++; if (ctl !== LU) begin errors++; $display("FAIL lu_rt got=%b exp=%b", ctl, LU); end
        cyc();
        rt_id = 5'd6;
        #1;
        checks++; if (ctl !== ADV) begin errors++; $display("FAIL lu_rt_miss got=%b exp=%b", ctl, ADV); end
        rw_ex = 5'd0; rs_id = 5'd0; use_rs_id = 1'b1;
        #1;
        checks++; if (ctl !== ADV) begin errors++; $display("FAIL lu_r0 got=%b exp=%b", ctl, ADV); end
        rw_ex = 5'd9; rs_id = 5'd9; wreg_ex = 1'b0;
        #1;
        checks++; if (ctl !== ADV) begin errors++; $display("FAIL lu_nowreg got=%b exp=%b", ctl, ADV); end
        wreg_ex = 1'b1; m2reg_ex = 1'b0;
        #1;
        checks++; if (ctl !== ADV) begin errors++; $display("FAIL lu_noload got=%b exp=%b", ctl, ADV); end
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL lu_cnt got=%0d exp=2", stall_cnt); end
    endtask

    task automatic test_branch();
        do_reset();
        m2reg_ex = 1'b1; wreg_ex = 1'b1; rw_ex = 5'd7; rt_id = 5'd7; use_rt_id = 1'b1;
        branch_taken_ex = 1'b1;
        #1;
        checks++; if (ctl !== BR) begin errors++; $display("FAIL br_over_lu got=%b exp=%b", ctl, BR); end
        cyc();
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL br_cnt got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_store_ack();
        do_reset();
        dmem_ack = 1'b1;
        cyc();
        dmem_ack = 1'b0;
        checks++; if (dmem_req !== 1'b0 || ctl !== ADV) begin errors++; $display("FAIL spur_ack got=%b/%b exp=0/%b", dmem_req, ctl, ADV); end
        wmem_me = 1'b1;
        #1;
        checks++; if (ctl !== HALT || dmem_req !== 1'b0) begin errors++; $display("FAIL st_t0 got=%b/%b exp=%b/0", ctl, dmem_req, HALT); end
        cyc();
        checks++; if (dmem_req !== 1'b1 || ctl !== HALT) begin errors++; $display("FAIL st_req got=%b/%b exp=1/%b", dmem_req, ctl, HALT); end
        cyc(2);
        dmem_ack = 1'b1;
        cyc();
        dmem_ack = 1'b0;
        #1;
        checks++; if (ctl !== ADV || dmem_req !== 1'b0) begin errors++; $display("FAIL st_release got=%b/%b exp=%b/0", ctl, dmem_req, ADV); end
        checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL st_cnt got=%0d exp=4", stall_cnt); end
        cyc();
        checks++; if (ctl !== HALT) begin errors++; $display("FAIL st_done_clr got=%b exp=%b", ctl, HALT); end
        cyc();
        checks++; if (dmem_req !== 1'b1 || stall_cnt !== 16'd5) begin errors++; $display("FAIL st_next got=%b/%0d exp=1/5", dmem_req, stall_cnt); end
    endtask

    task automatic test_timeout();
        do_reset();
        m2reg_me = 1'b1;
        cyc();
        cyc(15);
        checks++; if (dmem_req !== 1'b1 || mem_err !== 1'b0) begin errors++; $display("FAIL to_pre got=%b/%b exp=1/0", dmem_req, mem_err); end
        cyc();
        checks++; if (mem_err !== 1'b1 || dmem_req !== 1'b0 || ctl !== HALT) begin errors++; $display("FAIL to_err got=%b/%b/%b exp=1/0/%b", mem_err, dmem_req, ctl, HALT); end
        checks++; if (stall_cnt !== 16'd17) begin errors++; $display("FAIL to_cnt got=%0d exp=17", stall_cnt); end
        dmem_ack = 1'b1;
        cyc();
        dmem_ack = 1'b0;
        checks++; if (mem_err !== 1'b1 || ctl !== HALT || stall_cnt !== 16'd18) begin errors++; $display("FAIL to_sticky got=%b/%b/%0d exp=1/%b/18", mem_err, ctl, stall_cnt, HALT); end
        m2reg_me = 1'b0;
        reset_0 = 1'b0;
        #1;
        checks++; if (mem_err !== 1'b0 || stall_cnt !== 16'd0 || ctl !== ADV) begin errors++; $display("FAIL to_reset got=%b/%0d/%b exp=0/0/%b", mem_err, stall_cnt, ctl, ADV); end
        reset_0 = 1'b1;
        cyc();
    endtask

    task automatic test_ack_at_timeout();
        do_reset();
        wmem_me = 1'b1;
        cyc();
        cyc(15);
        dmem_ack = 1'b1;
        cyc();
        dmem_ack = 1'b0;
        #1;
        checks++; if (mem_err !== 1'b0 || dmem_req !== 1'b0 || ctl !== ADV) begin errors++; $display("FAIL ack_wins got=%b/%b/%b exp=0/0/%b", mem_err, dmem_req, ctl, ADV); end
        wmem_me = 1'b0;
        cyc();
    endtask

    task automatic test_async_reset();
        do_reset();
        m2reg_me = 1'b1;
        cyc(2);
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL ar_req got=%b exp=1", dmem_req); end
        #2;
        reset_0 = 1'b0;
        #1;
        checks++; if (dmem_req !== 1'b0 || stall_cnt !== 16'd0 || ctl !== HALT) begin errors++; $display("FAIL ar_abort got=%b/%0d/%b exp=0/0/%b", dmem_req, stall_cnt, ctl, HALT); end
        reset_0 = 1'b1;
        cyc();
        checks++; if (dmem_req !== 1'b1 || stall_cnt !== 16'd1) begin errors++; $display("FAIL ar_restart got=%b/%0d exp=1/1", dmem_req, stall_cnt); end
        m2reg_me = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_store_ack();
        test_timeout();
        test_ack_at_timeout();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
